// File: rtl/control_fsm.sv
// Multi-cycle RV32 control sequencer: fetch over a req/ack port, decode, then
// drive operand selects, ALU function, PC update, RF write and data requests.
module control_fsm #(
    parameter logic [31:0] RESET_IR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        io_mem_req,
    output logic        io_mem_we,
    input  logic        io_mem_ack,
    input  logic [31:0] io_mem_rdata,
    input  logic        io_br_taken,
    output logic [31:0] io_ir,
    output logic [1:0]  io_opa_sel,
    output logic        io_opb_sel,
    output logic [3:0]  io_alu_fun,
    output logic        io_pc_en,
    output logic        io_pc_sel,
    output logic        io_rf_wen,
    output logic        io_illegal,
    output logic [2:0]  io_state
);

    // state  | meaning
    // FETCH  | instruction request outstanding, IR loads on ack
    // DECODE | classify IR, trap unsupported opcodes
    // EXEC   | ALU phase; branches resolve the PC here
    // MEM    | data request outstanding until ack
    // WB     | register-file write and PC+4
    // HALT   | illegal instruction seen; only reset leaves
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_t      state_q;
    logic [31:0] ir_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_op, is_imm, is_lui, is_load, is_store, is_branch, is_csri;
    logic       is_legal;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign is_op     = (opcode == OPC_OP);
    assign is_imm    = (opcode == OPC_OP_IMM);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    // Only the CSR immediate forms (funct3 5..7) are handled.
    assign is_csri   = (opcode == OPC_SYSTEM) && (funct3 >= 3'd5);
    assign is_legal  = is_op | is_imm | is_lui | is_load | is_store | is_branch | is_csri;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= RESET_IR;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (io_mem_ack) begin
                        ir_q    <= io_mem_rdata;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: state_q <= is_legal ? S_EXEC : S_HALT;
                S_EXEC: begin
                    if (is_load || is_store) state_q <= S_MEM;
                    else if (is_branch)      state_q <= S_FETCH;
                    else                     state_q <= S_WB;
                end
                S_MEM: begin
                    if (io_mem_ack) state_q <= is_store ? S_FETCH : S_WB;
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    logic       req_c, we_c, pc_en_c, pc_sel_c, rf_wen_c, illegal_c;
    logic [1:0] opa_c;

    always_comb begin
        req_c     = 1'b0;
        we_c      = 1'b0;
        pc_en_c   = 1'b0;
        pc_sel_c  = 1'b0;
        rf_wen_c  = 1'b0;
        illegal_c = 1'b0;
        opa_c     = is_lui ? 2'd1 : (is_csri ? 2'd2 : 2'd0);
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                opa_c = 2'd0;
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_en_c  = 1'b1;
                    pc_sel_c = io_br_taken;
                end
            end
            S_MEM: begin
                req_c   = 1'b1;
                we_c    = is_store;
                pc_en_c = is_store && io_mem_ack;
            end
            S_WB: begin
                rf_wen_c = (ir_q[11:7] != 5'd0);
                pc_en_c  = 1'b1;
            end
            S_HALT: begin
                illegal_c = 1'b1;
                opa_c     = 2'd3;
            end
            default: ;
        endcase
    end

    always_comb begin
        io_alu_fun = 4'h0;
        if (is_op)                 io_alu_fun = {ir_q[30], funct3};
        else if (is_imm)           io_alu_fun = {(funct3 == 3'd5) ? ir_q[30] : 1'b0, funct3};
        else if (is_lui || is_csri) io_alu_fun = 4'hF;
    end

    // Strobes and the debug state are masked while reset is held.
    assign io_mem_req = req_c & ~reset;
    assign io_mem_we  = we_c & ~reset;
    assign io_pc_en   = pc_en_c & ~reset;
    assign io_rf_wen  = rf_wen_c & ~reset;
    assign io_illegal = illegal_c & ~reset;
    assign io_state   = reset ? 3'd0 : state_q;
    assign io_pc_sel  = pc_sel_c;
    assign io_opa_sel = opa_c;
    assign io_opb_sel = is_imm | is_load | is_store;
    assign io_ir      = ir_q;

endmodule

// File: tb/tb_control_fsm.sv
// Randomized bench for control_fsm: each instruction is expanded into its
// expected phase sequence and every cycle is compared against that model.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_mem_req, io_mem_we, io_mem_ack, io_br_taken;
    logic [31:0] io_mem_rdata, io_ir;
    logic [1:0]  io_opa_sel;
    logic        io_opb_sel, io_pc_en, io_pc_sel, io_rf_wen, io_illegal;
    logic [3:0]  io_alu_fun;
    logic [2:0]  io_state;

    int checks = 0;
    int errors = 0;

    localparam int C_OP = 0, C_IMM = 1, C_LUI = 2, C_LOAD = 3, C_STORE = 4,
                   C_BR = 5, C_CSRI = 6, C_ILL = 7;

    control_fsm dut (
        .clk(clk), .reset(reset),
        .io_mem_req(io_mem_req), .io_mem_we(io_mem_we), .io_mem_ack(io_mem_ack),
        .io_mem_rdata(io_mem_rdata), .io_br_taken(io_br_taken), .io_ir(io_ir),
        .io_opa_sel(io_opa_sel), .io_opb_sel(io_opb_sel), .io_alu_fun(io_alu_fun),
        .io_pc_en(io_pc_en), .io_pc_sel(io_pc_sel), .io_rf_wen(io_rf_wen),
        .io_illegal(io_illegal), .io_state(io_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int classify(input logic [31:0] w);
        case (w[6:0])
            7'b0110011: return C_OP;
            7'b0010011: return C_IMM;
            7'b0110111: return C_LUI;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b1100011: return C_BR;
            7'b1110011: return (w[14:12] >= 3'd5) ? C_CSRI : C_ILL;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] exp_alu(input logic [31:0] w, input int c);
        case (c)
            C_OP:          return {w[30], w[14:12]};
            C_IMM:         return {(w[14:12] == 3'd5) ? w[30] : 1'b0, w[14:12]};
            C_LUI, C_CSRI: return 4'hF;
            default:       return 4'h0;
        endcase
    endfunction

    // Entered and left at posedge+1; expects the DUT to be in FETCH on entry.
    task automatic run_instr(input logic [31:0] w, input int fdly, input int mdly, input bit br);
        int c = classify(w);
        int st_q[$];
        bit ack_q[$];
        for (int i = 0; i < fdly; i++) begin st_q.push_back(0); ack_q.push_back(0); end
        st_q.push_back(0); ack_q.push_back(1);
        st_q.push_back(1); ack_q.push_back(0);
        if (c == C_ILL) begin
            st_q.push_back(5); ack_q.push_back(0);
        end else begin
            st_q.push_back(2); ack_q.push_back(0);
            if (c == C_LOAD || c == C_STORE) begin
                for (int i = 0; i < mdly; i++) begin st_q.push_back(3); ack_q.push_back(0); end
                st_q.push_back(3); ack_q.push_back(1);
                if (c == C_LOAD) begin st_q.push_back(4); ack_q.push_back(0); end
            end else if (c != C_BR) begin
                st_q.push_back(4); ack_q.push_back(0);
            end
        end
        for (int k = 0; k < st_q.size(); k++) begin
            int  st = st_q[k];
            bit  ack = ack_q[k];
            bit  e_req, e_we, e_pc, e_sel, e_rf, e_ill;
            logic [1:0] e_opa;
            logic [9:0] got, exp;
            io_mem_ack   = (st == 0 || st == 3) ? ack : 1'($urandom_range(0, 1));
            io_mem_rdata = (st == 0 && ack) ? w : $urandom;
            io_br_taken  = (st == 2) ? br : 1'($urandom_range(0, 1));
            e_req = (st == 0 || st == 3);
            e_we  = (st == 3 && c == C_STORE);
            e_pc  = (st == 2 && c == C_BR) || (st == 3 && ack && c == C_STORE) || (st == 4);
            e_sel = (st == 2 && c == C_BR) ? br : 1'b0;
            e_rf  = (st == 4) && (w[11:7] != 5'd0);
            e_ill = (st == 5);
            e_opa = (st == 0) ? 2'd0 : (st == 5) ? 2'd3 :
                    (c == C_LUI) ? 2'd1 : (c == C_CSRI) ? 2'd2 : 2'd0;
            exp = {3'(st), e_req, e_we, e_pc, e_rf, e_ill, e_opa};
            @(negedge clk);
            got = {io_state, io_mem_req, io_mem_we, io_pc_en, io_rf_wen, io_illegal, io_opa_sel};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ctrl ir=%h cyc=%0d {st,req,we,pc,rf,ill,opa}: got %b exp %b", w, k, got, exp);
            end
            if (e_pc) begin
                checks++;
                if (io_pc_sel !== e_sel) begin
                    errors++;
                    $display("FAIL pc_sel ir=%h cyc=%0d: got %b exp %b", w, k, io_pc_sel, e_sel);
                end
            end
            if (st >= 1 && st <= 4) begin
                checks++;
                if ({io_ir, io_opb_sel, io_alu_fun} !== {w, (c == C_IMM || c == C_LOAD || c == C_STORE), exp_alu(w, c)}) begin
                    errors++;
                    $display("FAIL datapath ir=%h cyc=%0d: got ir=%h opb=%b alu=%h exp opb=%b alu=%h",
                             w, k, io_ir, io_opb_sel, io_alu_fun,
                             (c == C_IMM || c == C_LOAD || c == C_STORE), exp_alu(w, c));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io_mem_ack = 1'b1;
        io_mem_rdata = 32'hDEADBEEF;
        io_br_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({io_state, io_mem_req, io_mem_we, io_pc_en, io_rf_wen, io_illegal} !== 8'b0) begin
                errors++;
                $display("FAIL reset_forced: got st=%0d req=%b we=%b pc=%b rf=%b ill=%b exp all 0",
                         io_state, io_mem_req, io_mem_we, io_pc_en, io_rf_wen, io_illegal);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        io_mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({io_state, io_mem_req, io_illegal, io_ir} !== {3'd0, 1'b1, 1'b0, 32'h00000013}) begin
            errors++;
            $display("FAIL reset_release: got st=%0d req=%b ill=%b ir=%h exp st=0 req=1 ill=0 ir=00000013",
                     io_state, io_mem_req, io_illegal, io_ir);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_instr(32'h00500093, 0, 0, 1'b0);
        run_instr(32'h123450B7, 0, 0, 1'b0);
        run_instr(32'h0000D073, 0, 0, 1'b0);
        run_instr(32'h0020A023, 0, 3, 1'b0);
        run_instr(32'h00208463, 0, 0, 1'b1);
        run_instr(32'h0000A103, 2, 1, 1'b0);
        run_instr(32'h4020D0B3, 1, 0, 1'b0);
    endtask

    task automatic test_halt(input logic [31:0] w);
        run_instr(w, 0, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            io_mem_ack = 1'($urandom_range(0, 1));
            io_mem_rdata = 32'h00500093;
            @(negedge clk);
            checks++;
            if ({io_state, io_illegal, io_opa_sel, io_mem_req, io_pc_en, io_rf_wen, io_mem_we} !==
                {3'd5, 1'b1, 2'd3, 4'b0}) begin
                errors++;
                $display("FAIL halt_hold ir=%h cyc=%0d: got st=%0d ill=%b opa=%0d req=%b pc=%b rf=%b we=%b",
                         w, i, io_state, io_illegal, io_opa_sel, io_mem_req, io_pc_en, io_rf_wen, io_mem_we);
            end
            @(posedge clk); #1;
        end
        test_reset();
    endtask

    task automatic test_reset_mid_request();
        io_mem_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        io_mem_ack = 1'b1;
        io_mem_rdata = 32'h00500093;
        @(posedge clk); #1;
        reset = 1'b0;
        io_mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({io_state, io_ir} !== {3'd0, 32'h00000013}) begin
            errors++;
            $display("FAIL reset_vs_ack: got st=%0d ir=%h exp st=0 ir=00000013", io_state, io_ir);
        end
        @(posedge clk); #1;
        io_mem_ack = 1'b1;
        io_mem_rdata = 32'h0020A023;
        @(posedge clk); #1;
        io_mem_ack = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if ({io_state, io_mem_req, io_mem_we} !== {3'd3, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mid_mem_reach: got st=%0d req=%b we=%b exp st=3 req=1 we=1", io_state, io_mem_req, io_mem_we);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        io_mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({io_mem_req, io_pc_en, io_rf_wen, io_state} !== 6'b0) begin
            errors++;
            $display("FAIL mid_mem_reset: got req=%b pc=%b rf=%b st=%0d exp all 0", io_mem_req, io_pc_en, io_rf_wen, io_state);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        io_mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({io_state, io_ir, io_pc_en} !== {3'd0, 32'h00000013, 1'b0}) begin
            errors++;
            $display("FAIL mid_mem_after: got st=%0d ir=%h pc=%b exp st=0 ir=00000013 pc=0", io_state, io_ir, io_pc_en);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [6:0] opcs [7];
        opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011};
        for (int n = 0; n < 60; n++) begin
            logic [31:0] w = $urandom;
            int sel = $urandom_range(0, 6);
            w[6:0] = opcs[sel];
            if (sel == 6) w[14:12] = 3'($urandom_range(5, 7));
            if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
            run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        reset = 1'b1;
        io_mem_ack = 1'b0;
        io_mem_rdata = 32'h0;
        io_br_taken = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_reset_mid_request();
        test_random();
        test_halt(32'h00000073);
        test_halt(32'hFFFFFFFF);
        run_instr(32'h00500093, 0, 0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
